sync_clk_divider: RTL and testbench
===================================

Name: sync_clk_divider

Overview:
- Parametrised, fully synchronous successor to the ripple toggle-flop divider chain.
- Produces a divided square wave (out) and a one-cycle period tick (tick) from clk, using one counter instead of cascaded clocks.
- Divisor is run-time programmable through a valid/ready handshake and takes effect glitch-free at a period boundary.
- Feeds clock-enable consumers; no derived signal is ever used as a clock.

Parameters:
- CNT_W, 16, counter and divisor width in bits.
- DEF_DIV, 4, active divisor after reset; must be in 2..2^CNT_W-1.
- TAP_N, 4, number of binary prescaler taps, used only when TAPS_EN is defined.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; low freezes all counting state.
- div_val  input  CNT_W  requested divisor N.
- div_valid  input  1  div_val is offered.
- div_ready  output  1  pending slot empty; a transfer occurs when div_valid and div_ready are both high at an edge.
- out  output  1  registered divided square wave.
- tick  output  1  registered one-cycle pulse in the last cycle of each period.
- err  output  1  sticky flag: an illegal divisor (0 or 1) was accepted.
- cur_div  output  CNT_W  divisor currently in effect.

Behaviour:
- Reset values (all asynchronous on rst high): cnt=0, out=0, tick=0, err=0, cur_div=DEF_DIV, pending slot empty, div_ready=1.
- Counting, on each edge with en=1:
  - cnt_nxt = (cnt==cur_div-1) ? 0 : cnt+1.
  - out <= (cnt_nxt < HI), where HI = ceil(cur_div/2). Odd N gives the extra high cycle.
  - tick <= (cnt_nxt == cur_div-1).
- en=0: cnt, out and tick hold. tick is forced to 0 while en=0. The handshake still operates.
- First period after reset: out stays 0 until the first enabled edge, then follows the rule above. For N=4 the sequence is 1,0,0,1,1,0,0,...
- Handshake:
  - div_ready = pending slot empty.
  - An accepted value is stored in the slot; div_ready drops on the next edge.
  - Accepted values 0 or 1 are clamped to 2 and set err. err clears only on rst.
- Apply point: a pending value is copied into cur_div on the enabled edge where cnt==cur_div-1 (cnt wraps to 0). The slot empties on that same edge, so div_ready is high again on the next cycle.
- A value accepted on the apply edge is not possible, because div_ready is low there. There is no same-edge accept-and-apply bypass.
- The new divisor governs cnt_nxt=0 onward; out and tick for the wrapping edge are computed with the new divisor.
- Wrap-around: cnt never exceeds cur_div-1 ≤ 2^CNT_W-2, so there is no counter overflow.
- rst asserted mid-operation discards the pending value and restores DEF_DIV immediately. There is no partial-period carry-over.
- Latency: tick is registered and asserts during the cycle in which cnt==N-1.

Optional Feature:
- Macro: SYNC_CLK_DIVIDER_TAPS_EN.
- Defined:
  - Adds output taps[TAP_N-1:0], driven by a free-running synchronous binary counter advanced on enabled edges and reset to 0.
  - Bit k toggles every 2^k enabled cycles, giving a synchronous replacement for the ripple chain. taps[1] equals the legacy divide-by-4 output, without ripple skew.
  - taps is independent of cur_div and of the handshake.
- Undefined: the taps port and its counter do not exist. All other behaviour is identical.

Decomposition:
- Package clkdiv_pkg holds:
  - MIN_DIV=2.
  - Default CNT_W.
  - Function hi_len(N) = (N+1)>>1.
  - Function clamp_div(N) returning max(N, MIN_DIV) plus an illegal flag.
- One sub-module, div_cfg_slot:
  - Single-entry pending register with valid/ready, clamp and err logic.
  - Exposes pend_valid, pend_div and an apply strobe input.
- The counter and out/tick logic stay in sync_clk_divider.

Test Plan:
- Reset, en=1, DEF_DIV=4, no loads -> out 1,0,0,1,1,0,0,1... over edges 1..8; tick high when cnt=3 (cycles 3,7,...); cur_div=4; err=0.
- At cnt=1 with N=4, offer div_val=5 with div_valid -> accepted, div_ready=0; cur_div stays 4 until the wrap edge, then 5. Thereafter out is 3 high / 2 low and tick fires every 5 cycles; div_ready returns to 1 the cycle after the wrap.
- div_val=1 accepted -> applied as 2, err=1 sticky; out toggles every enabled cycle and tick fires every 2 cycles; a later div_val=6 does not clear err.
- Hold en=0 for 3 cycles mid-period with N=5 -> cnt and out frozen, tick=0; resumes exactly where it stopped; apply is deferred until the real wrap.
- With the slot full, a second div_valid=1 (value 9) -> not accepted while div_ready=0; accepted on the first cycle after apply, then applied at the next wrap.
- Assert rst asynchronously mid-period with a pending value -> out=0, tick=0, cur_div=DEF_DIV, div_ready=1 without waiting for a clk edge; the pending value is lost.
- With SYNC_CLK_DIVIDER_TAPS_EN defined -> taps[0] toggles every cycle and taps[1] every 2 cycles while en=1, regardless of cur_div.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the synchronous clock divider.
// Divisor arithmetic is done on 32-bit values and narrowed by the caller.
package clkdiv_pkg;

  localparam int MIN_DIV   = 2;
  localparam int DEF_CNT_W = 16;

  // div is the MSB field so a caller can narrow the packed result to {div[W-1:0], illegal}.
  typedef struct packed {
    logic [31:0] div;
    logic        illegal;
  } clamp_t;

  function automatic logic [31:0] hi_len(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

  function automatic clamp_t clamp_div(input logic [31:0] n);
    clamp_t r;
    r.illegal = (n < 32'(MIN_DIV));
    r.div     = r.illegal ? 32'(MIN_DIV) : n;
    return r;
  endfunction

endpackage

// File: rtl/div_cfg_slot.sv
// Single-entry pending divisor register with valid/ready intake, clamp to MIN_DIV
// and a sticky illegal-divisor flag.
module div_cfg_slot
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             apply,
  output logic             pend_valid,
  output logic [CNT_W-1:0] pend_div,
  output logic             err
);

  // Handshake: a value transfers on any edge where div_valid and div_ready are both high;
  // div_ready is simply "slot empty", so it never depends on div_valid.
  logic             r_pend_valid;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_err;
  logic [CNT_W-1:0] w_clamp_div;
  logic             w_illegal;
  logic             w_accept;

  assign {w_clamp_div, w_illegal} = (CNT_W + 1)'(clamp_div(32'(div_val)));
  assign w_accept = div_valid & ~r_pend_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_valid <= 1'b0;
      r_pend_div   <= '0;
      r_err        <= 1'b0;
    end else if (apply) begin
      r_pend_valid <= 1'b0;
    end else if (w_accept) begin
      r_pend_valid <= 1'b1;
      r_pend_div   <= w_clamp_div;
      if (w_illegal) r_err <= 1'b1;
    end
  end

  assign div_ready  = ~r_pend_valid;
  assign pend_valid = r_pend_valid;
  assign pend_div   = r_pend_div;
  assign err        = r_err;

endmodule

// File: rtl/sync_clk_divider.sv
// Single-counter programmable divider producing a square wave and a period tick.
// Optional prescaler taps output when SYNC_CLK_DIVIDER_TAPS_EN is defined.
module sync_clk_divider
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DEF_DIV = 4,
  parameter int TAP_N   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             out,
  output logic             tick,
  output logic             err,
`ifdef SYNC_CLK_DIVIDER_TAPS_EN
  output logic [TAP_N-1:0] taps,
`endif
  output logic [CNT_W-1:0] cur_div
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cur_div;
  logic             r_out;
  logic             r_tick;
  logic             w_wrap;
  logic             w_apply;
  logic             w_pend_valid;
  logic [CNT_W-1:0] w_pend_div;
  logic [CNT_W-1:0] w_div_eff;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_hi;

  div_cfg_slot #(.CNT_W(CNT_W)) u_slot (
    .clk        (clk),
    .rst        (rst),
    .div_val    (div_val),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .apply      (w_apply),
    .pend_valid (w_pend_valid),
    .pend_div   (w_pend_div),
    .err        (err)
  );

  // The pending divisor takes over on the wrap edge, so the wrap edge's out/tick use it.
  assign w_wrap    = (r_cnt == r_cur_div - CNT_W'(1));
  assign w_apply   = en & w_wrap & w_pend_valid;
  assign w_div_eff = w_apply ? w_pend_div : r_cur_div;
  assign w_cnt_nxt = w_wrap ? '0 : r_cnt + CNT_W'(1);
  assign w_hi      = CNT_W'(hi_len(32'(w_div_eff)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_out     <= 1'b0;
      r_tick    <= 1'b0;
      r_cur_div <= CNT_W'(DEF_DIV);
    end else if (en) begin
      r_cnt  <= w_cnt_nxt;
      r_out  <= (w_cnt_nxt < w_hi);
      r_tick <= (w_cnt_nxt == w_div_eff - CNT_W'(1));
      if (w_apply) r_cur_div <= w_pend_div;
    end
  end

  // A held tick reappears when en returns, so each period still gets exactly one enabled tick.
  assign out     = r_out;
  assign tick    = r_tick & en;
  assign cur_div = r_cur_div;

`ifdef SYNC_CLK_DIVIDER_TAPS_EN
  logic [TAP_N-1:0] r_taps;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     r_taps <= '0;
    else if (en) r_taps <= r_taps + TAP_N'(1);
  end

  assign taps = r_taps;
`else
  if (TAP_N < 1) begin : g_tap_chk
    $error("TAP_N must be at least 1");
  end
`endif

endmodule

// File: tb/tb_sync_clk_divider.sv
// Randomized scoreboard bench for sync_clk_divider against a period-level waveform model.
// Checks taps as well when SYNC_CLK_DIVIDER_TAPS_EN is defined.
module tb_sync_clk_divider;

  localparam int CNT_W   = 16;
  localparam int DEF_DIV = 4;
  localparam int TAP_N   = 4;
  localparam int W       = TAP_N + 4 + CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_valid;
  logic             div_ready;
  logic             out;
  logic             tick;
  logic             err;
  logic [CNT_W-1:0] cur_div;
  logic [TAP_N-1:0] act_taps;
`ifdef SYNC_CLK_DIVIDER_TAPS_EN
  logic [TAP_N-1:0] taps;
  assign act_taps = taps;
`else
  assign act_taps = '0;
`endif

  always #5 clk = ~clk;

  sync_clk_divider #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV), .TAP_N(TAP_N)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_val   (div_val),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .out       (out),
    .tick      (tick),
    .err       (err),
`ifdef SYNC_CLK_DIVIDER_TAPS_EN
    .taps      (taps),
`endif
    .cur_div   (cur_div)
  );

  logic [W-1:0] exp_q[$];
  int n_tests  = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int n_popped = 0;

  // Reference model: the waveform of a period of length N is the list of
  // (out,tick) values for its N enabled edges, starting at the wrap edge.
  logic [1:0] wave_q[$];
  int         m_div;
  bit         m_pend;
  int         m_pend_div;
  bit         m_err;
  bit         m_out;
  bit         m_tick;
  int         m_taps;

  function automatic logic [W-1:0] pack(input logic [TAP_N-1:0] tp, input logic o,
                                        input logic t, input logic r, input logic e,
                                        input logic [CNT_W-1:0] d);
    return {tp, o, t, r, e, d};
  endfunction

  function automatic logic [W-1:0] actual();
    return pack(act_taps, out, tick, div_ready, err, cur_div);
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got taps/out/tick/rdy/err/div=%h required=%h", name, $time, got, exp);
    end
  endtask

  task automatic start_period(input int n, input bit skip_first);
    for (int i = 0; i < n; i++) begin
      if (!(skip_first && i == 0))
        wave_q.push_back({(i < (n + 1) / 2) ? 1'b1 : 1'b0, (i == n - 1) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic model_reset();
    wave_q.delete();
    // Reset state behaves as if the wrap edge of a DEF_DIV period has just happened.
    start_period(DEF_DIV, 1'b1);
    m_div = DEF_DIV; m_pend = 0; m_pend_div = 0; m_err = 0;
    m_out = 0; m_tick = 0; m_taps = 0;
  endtask

  task automatic model_edge(input bit e, input bit v, input int d);
    bit         ready_before;
    logic [1:0] w;
    ready_before = !m_pend;
    if (e) begin
      if (wave_q.size() == 0) begin
        if (m_pend) begin
          m_div  = m_pend_div;
          m_pend = 0;
        end
        start_period(m_div, 1'b0);
      end
      w = wave_q.pop_front();
      m_out  = w[1];
      m_tick = w[0];
      m_taps++;
    end
    if (v && ready_before) begin
      m_pend     = 1;
      m_pend_div = (d < 2) ? 2 : d;
      if (d < 2) m_err = 1;
    end
  endtask

  task automatic push_exp(input bit e_now);
    logic [TAP_N-1:0] tp;
`ifdef SYNC_CLK_DIVIDER_TAPS_EN
    tp = m_taps[TAP_N-1:0];
`else
    tp = '0;
`endif
    exp_q.push_back(pack(tp, m_out, m_tick & e_now, !m_pend, m_err, m_div[CNT_W-1:0]));
    n_pushed++;
  endtask

  // Called just after a rising edge: holds inputs for one cycle and queues that cycle's outputs.
  task automatic step(input bit e, input bit v, input int d);
    en        = e;
    div_valid = v;
    div_val   = d[CNT_W-1:0];
    push_exp(e);
    @(posedge clk);
    model_edge(e, v, d);
    #1;
  endtask

  task automatic release_reset();
    en = 1'b0; div_valid = 1'b0; div_val = '0;
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset(input string name);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check(name, actual(), pack('0, 1'b0, 1'b0, 1'b1, 1'b0, CNT_W'(DEF_DIV)));
    model_reset();
    @(posedge clk);
    #1;
    release_reset();
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_popped++;
        check("cycle", actual(), e);
      end
    end
  end

  initial begin : driver
    rst = 1'b1; en = 1'b0; div_valid = 1'b0; div_val = '0;
    model_reset();
    #3 check("reset_state", actual(), pack('0, 1'b0, 1'b0, 1'b1, 1'b0, CNT_W'(DEF_DIV)));
    release_reset();

    for (int i = 0; i < 8; i++) step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 5);
    for (int i = 0; i < 14; i++) step(1, 0, 0);

    step(1, 1, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    step(1, 1, 6);
    for (int i = 0; i < 16; i++) step(1, 0, 0);

    step(1, 1, 5);
    for (int i = 0; i < 14; i++) step(1, 0, 0);
    step(1, 1, 7);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    for (int i = 0; i < 14; i++) step(1, 0, 0);

    step(1, 1, 3);
    for (int i = 0; i < 10; i++) step(1, 1, 9);
    for (int i = 0; i < 12; i++) step(1, 0, 0);

    step(1, 1, 8);
    step(1, 0, 0);
    async_reset("rst_pending");
    for (int i = 0; i < 10; i++) step(1, 0, 0);

    for (int i = 0; i < 2500; i++) begin
      if (i == 1250) async_reset("rst_random");
      step(($urandom_range(0, 6) != 0), ($urandom_range(0, 4) == 0), int'($urandom_range(0, 9)));
    end

    en = 1'b0; div_valid = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (n_popped != n_pushed) begin
      n_fail++;
      $display("FAIL drain: popped=%0d required=%0d", n_popped, n_pushed);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
